// File: rtl/ram_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port RAM with one access per cycle.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise the data port always wins.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_sel,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        ram_ce,
    output logic        ram_re,
    output logic        ram_we,
    output logic [31:0] ram_read_addr,
    output logic [31:0] ram_write_addr,
    output logic [31:0] ram_write_data,
    output logic [3:0]  ram_write,
    input  logic [31:0] ram_read_data
);

    logic        grant_if;
    logic        grant_dm;
    logic        prefer_dm;
    logic        if_rvalid_reg;
    logic        dm_rvalid_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] dm_rdata_reg;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the data port won the last accepted access, 0 = fetch
    logic last_grant_reg;

    always_comb begin
        prefer_dm = ~last_grant_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b0;
        end else if (grant_if || grant_dm) begin
            last_grant_reg <= grant_dm;
        end
    end
`else
    always_comb begin
        prefer_dm = 1'b1;
    end
`endif

    // Reset gates the grants combinationally so nothing reaches the RAM while rst_n is low
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (rst_n) begin
            if (dm_req && (!if_req || prefer_dm)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        ram_ce         = 1'b0;
        ram_re         = 1'b0;
        ram_we         = 1'b0;
        ram_read_addr  = 32'h0;
        ram_write_addr = 32'h0;
        ram_write_data = 32'h0;
        ram_write      = 4'b0000;
        if (grant_if) begin
            ram_ce        = 1'b1;
            ram_re        = 1'b1;
            ram_read_addr = if_addr;
        end else if (grant_dm) begin
            ram_ce = 1'b1;
            if (dm_we) begin
                ram_we         = 1'b1;
                ram_write_addr = dm_addr;
                ram_write_data = dm_wdata;
                ram_write      = dm_sel;
            end else begin
                ram_re        = 1'b1;
                ram_read_addr = dm_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_reg <= 1'b0;
            dm_rvalid_reg <= 1'b0;
            if_rdata_reg  <= 32'h0;
            dm_rdata_reg  <= 32'h0;
        end else begin
            if_rvalid_reg <= grant_if;
            dm_rvalid_reg <= grant_dm;
            if (grant_if) begin
                if_rdata_reg <= ram_read_data;
            end
            // A write acknowledge pulses rvalid but keeps the last read data
            if (grant_dm && !dm_we) begin
                dm_rdata_reg <= ram_read_data;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_rvalid = if_rvalid_reg;
    assign dm_rvalid = dm_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-lane RAM model that writes on the falling edge.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_sel;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        ram_ce;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_read_addr;
    logic [31:0] ram_write_addr;
    logic [31:0] ram_write_data;
    logic [3:0]  ram_write;
    logic [31:0] ram_read_data;

    logic [31:0] mem [0:63];
    int n_assert = 0;
    int n_fail   = 0;

    ram_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_sel         (dm_sel),
        .dm_gnt         (dm_gnt),
        .dm_rvalid      (dm_rvalid),
        .dm_rdata       (dm_rdata),
        .ram_ce         (ram_ce),
        .ram_re         (ram_re),
        .ram_we         (ram_we),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_write      (ram_write),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    assign ram_read_data = mem[ram_read_addr[7:2]];

    always @(negedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_write[b]) mem[ram_write_addr[7:2]][8*b +: 8] = ram_write_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'hA000_0000;
        mem[1]  = 32'hA000_0004;
        mem[2]  = 32'hA000_0008;
        mem[4]  = 32'hDEAD_BEEF;
        mem[8]  = 32'hAABB_CCDD;

        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = 32'h0; dm_sel = 4'b0;
        #3;
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_dm_gnt", {31'b0, dm_gnt}, 32'd0);
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        tick(); tick();
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("idle_ce", {31'b0, ram_ce}, 32'd0);
        chk("idle_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("idle_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        chk("idle_if_rdata", if_rdata, 32'h0);
        chk("idle_dm_rdata", dm_rdata, 32'h0);

        // Single fetch from 0x10
        if_req = 1'b1; if_addr = 32'h10; #1;
        chk("f_gnt", {31'b0, if_gnt}, 32'd1);
        chk("f_dm_gnt", {31'b0, dm_gnt}, 32'd0);
        chk("f_ctl", {29'b0, ram_ce, ram_re, ram_we}, 32'b110);
        chk("f_raddr", ram_read_addr, 32'h10);
        tick(); if_req = 1'b0; #1;
        chk("f_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("f_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("f_idle_ce", {31'b0, ram_ce}, 32'd0);
        tick();
        chk("f_rvalid_drop", {31'b0, if_rvalid}, 32'd0);
        chk("f_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Partial write then read back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1122_3344; dm_sel = 4'b0101; #1;
        chk("w_gnt", {31'b0, dm_gnt}, 32'd1);
        chk("w_ctl", {29'b0, ram_ce, ram_re, ram_we}, 32'b101);
        chk("w_lanes", {28'b0, ram_write}, 32'b0101);
        chk("w_waddr", ram_write_addr, 32'h20);
        chk("w_wdata", ram_write_data, 32'h1122_3344);
        tick(); dm_we = 1'b0; #1;
        chk("w_ack", {31'b0, dm_rvalid}, 32'd1);
        chk("w_rdata_keep", dm_rdata, 32'h0);
        chk("r_raddr", ram_read_addr, 32'h20);
        tick(); dm_req = 1'b0; #1;
        chk("r_rvalid", {31'b0, dm_rvalid}, 32'd1);
        chk("r_rdata", dm_rdata, 32'hAA22_CC44);

        // Write with no byte enables leaves RAM untouched
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_wdata = 32'hFFFF_FFFF; dm_sel = 4'b0000; #1;
        chk("z_gnt", {31'b0, dm_gnt}, 32'd1);
        chk("z_we", {31'b0, ram_we}, 32'd1);
        chk("z_lanes", {28'b0, ram_write}, 32'd0);
        tick(); dm_req = 1'b0; dm_we = 1'b0; #1;
        chk("z_ack", {31'b0, dm_rvalid}, 32'd1);
        chk("z_mem", mem[8], 32'hAA22_CC44);
        chk("z_rdata_keep", dm_rdata, 32'hAA22_CC44);

        // Back-to-back fetches
        tick();
        if_req = 1'b1; if_addr = 32'h0;
        tick(); if_addr = 32'h4; #1;
        chk("b2b_v0", {31'b0, if_rvalid}, 32'd1);
        chk("b2b_d0", if_rdata, 32'hA000_0000);
        tick(); if_addr = 32'h8; #1;
        chk("b2b_v1", {31'b0, if_rvalid}, 32'd1);
        chk("b2b_d1", if_rdata, 32'hA000_0004);
        tick(); if_req = 1'b0; #1;
        chk("b2b_v2", {31'b0, if_rvalid}, 32'd1);
        chk("b2b_d2", if_rdata, 32'hA000_0008);
        tick();
        chk("b2b_end", {31'b0, if_rvalid}, 32'd0);

        // Contention for 4 cycles; the last accepted access was a fetch
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("cont_dm_gnt%0d", i), {31'b0, dm_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont_if_gnt%0d", i), {31'b0, if_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
`else
            chk($sformatf("cont_dm_gnt%0d", i), {31'b0, dm_gnt}, 32'd1);
            chk($sformatf("cont_if_gnt%0d", i), {31'b0, if_gnt}, 32'd0);
`endif
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0; #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("cont_last_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("cont_last_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
`else
        chk("cont_last_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("cont_last_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
`endif
        chk("cont_dm_rdata", dm_rdata, 32'hAA22_CC44);

        // Reset asserted mid-cycle during a granted read
        tick();
        dm_req = 1'b1; dm_addr = 32'h20; #1;
        chk("mr_gnt", {31'b0, dm_gnt}, 32'd1);
        #2 rst_n = 1'b0; #1;
        chk("mr_gnt_drop", {31'b0, dm_gnt}, 32'd0);
        chk("mr_ce_drop", {31'b0, ram_ce}, 32'd0);
        chk("mr_rdata_clr", dm_rdata, 32'h0);
        tick();
        chk("mr_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
        dm_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("mr_idle_rvalid", {31'b0, dm_rvalid}, 32'd0);
        dm_req = 1'b1; #1;
        chk("mr_re_gnt", {31'b0, dm_gnt}, 32'd1);
        tick(); dm_req = 1'b0; #1;
        chk("mr_re_rvalid", {31'b0, dm_rvalid}, 32'd1);
        chk("mr_re_rdata", dm_rdata, 32'hAA22_CC44);

        // Pending response discarded by reset
        tick();
        if_req = 1'b1; if_addr = 32'h10;
        tick(); if_req = 1'b0; #1;
        chk("pd_rvalid", {31'b0, if_rvalid}, 32'd1);
        rst_n = 1'b0; #1;
        chk("pd_rvalid_clr", {31'b0, if_rvalid}, 32'd0);
        chk("pd_rdata_clr", if_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("pd_after", {31'b0, if_rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, sole clock; all state changes occur on the posedge.
REQ-002 rst_n, in, 1, reset; asynchronous and active-low.
REQ-003 if_req/if_addr, in, 1/32, fetch read request and byte address.
REQ-004 if_gnt, out, 1, fetch request accepted this cycle; if_rvalid/if_rdata, out, 1/32, fetch response.
REQ-005 dm_req/dm_we/dm_addr/dm_wdata/dm_sel, in, 1/1/32/32/4, data request: 1 = write; address; write data; byte enables with bit 3 = bits 31:24.
REQ-006 dm_gnt, out, 1, data request accepted this cycle; dm_rvalid/dm_rdata, out, 1/32, data response (read data or write acknowledge).
REQ-007 ram_ce/ram_re/ram_we, out, 1 each, RAM chip, read and write enables, all active-high.
REQ-008 ram_read_addr/ram_write_addr/ram_write_data/ram_write, out, 32/32/32/4, RAM address, data and byte-lane controls.
REQ-009 ram_read_data, in, 32, combinational RAM read data.

Function
REQ-010 The arbiter SHALL grant at most one requester per cycle, choosing combinationally from if_req and dm_req; exactly one of if_gnt and dm_gnt is high when any request is present.
REQ-011 Fetch grant: ram_ce=1, ram_re=1, ram_we=0, ram_read_addr=if_addr.
REQ-012 Data read grant: ram_ce=1, ram_re=1, ram_we=0, ram_read_addr=dm_addr.
REQ-013 Data write grant: ram_ce=1, ram_re=0, ram_we=1, ram_write_addr=dm_addr, ram_write_data=dm_wdata, ram_write=dm_sel; the RAM commits on the falling edge of the same cycle.
REQ-014 No grant: all RAM enables are 0 and ram_write is 4'b0000; address and data outputs are 0.
REQ-015 A request is accepted at the posedge ending the grant cycle, and the requester SHALL hold req and its operands stable until then.
REQ-016 A new request may be presented in the cycle after acceptance, giving one access per cycle back-to-back.
REQ-017 Latency: ram_read_data is registered into if_rdata/dm_rdata at the accepting posedge, and the matching rvalid is high for exactly the following cycle.
REQ-018 A write acknowledge asserts dm_rvalid for one cycle and leaves dm_rdata unchanged.
REQ-019 rdata registers hold their value until the next read response on that port.
REQ-020 Contention, with both requests high: resolved per REQ-026/027; the losing request stays pending with gnt=0 and is not lost.
REQ-021 dm_we=1 with dm_sel=4'b0000 SHALL be granted and acknowledged without modifying RAM (ram_we=1, ram_write=0).
REQ-022 State is limited to last_grant (1 bit), if_rvalid, dm_rvalid, if_rdata and dm_rdata.

Reset
REQ-023 While rst_n=0, all RAM enables and both gnt outputs SHALL be forced to 0 regardless of requests.
REQ-024 Asynchronous reset SHALL clear if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0 and last_grant=fetch.
REQ-025 A response pending when reset asserts SHALL be discarded, and the first cycle after release behaves as idle plus the current requests.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted at the last accepted access, with last_grant updated on every acceptance.
REQ-027 Macro ARB_ROUND_ROBIN_EN undefined: dm always wins contention, fetch may starve while dm_req stays high, and last_grant is unused and held at reset value.

Verification
REQ-028 Reset then idle: ram_ce=0, both rvalid=0, rdata=0.
REQ-029 Preload word 0x10 with 0xDEADBEEF; if_req=1, if_addr=0x10 for 1 cycle: if_gnt=1, then if_rvalid=1 and if_rdata=0xDEADBEEF in the next cycle.
REQ-030 Write 0x11223344 to 0x20 with dm_sel=4'b0101 over RAM 0xAABBCCDD, then read 0x20: dm_rdata=0xAA22CC44, with write ack dm_rvalid one cycle after the write.
REQ-031 if_req and dm_req both high for 4 cycles: with ARB_ROUND_ROBIN_EN, grants alternate starting with dm (last_grant=fetch after reset) as dm, if, dm, if; without it, dm for all 4 and if_gnt=0 throughout.
REQ-032 Assert rst_n=0 mid-cycle during a granted read: rvalid never asserts, outputs clear immediately, and the next read after release returns the correct data.
REQ-033 Back-to-back fetches 0x0, 0x4, 0x8: if_rvalid stays high for 3 consecutive cycles with data in order.
